store_queue_m: RTL and testbench
================================

// Module: store_queue_m
// PURPOSE
//  Memory-stage store path: encodes word/half/byte stores into byte-lane data plus byte enables.
//  Queues the encoded stores in a small FIFO and drains them to data RAM or the device bridge over a req/ack handshake.
//  Stalls the pipeline when the FIFO is full, or when a load hits a queued word.
//  Store-side counterpart of the writeback load-data selection/extension path.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, 2..16
//  AW      32  byte address width
// PORTS
//  clk          in   1     single clock, rising edge
//  reset        in   1     synchronous, active-high
//  MemWriteM    in   1     store instruction valid in M
//  MemTypeM     in   2     00 word, 01 half, 11 byte, 10 reserved
//  ALUOutM      in   AW    store/load byte address
//  WriteDataM   in   32    rt value; store data in low bits
//  MemorySelectM in  1     0 data RAM, 1 device bridge
//  FlushM       in   1     exception/interrupt kill of the M instruction
//  LoadM        in   1     load instruction valid in M (hazard check)
//  StallStoreM  out  1     pipeline stall: queue full on store, or load hazard
//  QueueEmpty   out  1     no pending stores (used by sync/eret drain)
//  MemReq       out  1     head entry valid toward memory
//  MemAddr      out  AW-2  head word address
//  MemWData     out  32    head lane-replicated data
//  MemBE        out  4     head byte enables, bit i = byte lane i (little-endian)
//  MemDevSel    out  1     head MemorySelect
//  MemAck       in   1     memory accepted head this cycle
//  AdESM        out  1     address-error-on-store (see CONFIGURATION)
// BEHAVIOUR
//  Reset: count=0, head/tail ptrs=0; MemReq=0, MemAddr=0, MemWData=0, MemBE=0, MemDevSel=0; QueueEmpty=1; StallStoreM=0; AdESM=0.
//  Encoding (a = ALUOutM[1:0]):
//   word: BE=4'b1111, data=WriteDataM.
//   half: BE = a[1] ? 4'b1100 : 4'b0011; data={2{WriteDataM[15:0]}}.
//   byte: BE = 4'b0001<<a; data={4{WriteDataM[7:0]}}.
//   reserved 10: encoded as word.
//  Enqueue at clk edge when MemWriteM & ~FlushM & ~full & ~AdESM.
//   Entry stores {ALUOutM[AW-1:2], data, BE, MemorySelectM}.
//  Full: enqueue refused even when a pop occurs in the same cycle.
//   StallStoreM = MemWriteM & ~FlushM & full; instruction retried next cycle.
//  Drain: MemReq = ~empty; head fields come straight from registered storage, so latency is 1 cycle from enqueue edge to MemReq.
//   Pop on MemReq & MemAck. Head fields must stay stable while MemReq=1 and MemAck=0.
//   MemAck while MemReq=0 is ignored.
//  Push and pop in the same cycle (not full): count unchanged, both pointers advance.
//  Pointers wrap modulo DEPTH; count is a 0..DEPTH range register.
//  Load hazard: LoadM & any valid entry with equal word address and equal MemorySelect drives StallStoreM=1.
//   Comparison is conservative: it includes the head even if acked this cycle.
//  FlushM only kills the current M store; entries already queued are committed and always drain.
//  Reset mid-drain: queue discarded immediately; MemReq=0 in the following cycle.
// CONFIGURATION
//  Macro STORE_MISALIGN_TRAP_EN:
//   Defined: a misaligned store (word with a!=0, half with a[0]=1) drives AdESM=1 combinationally in that cycle.
//    The store is not enqueued and does not stall. CP0 takes the exception; ALUOutM serves as BadVAddr.
//   Undefined: AdESM tied 0. Low address bits force-aligned: word ignores a, half ignores a[0].
// STRUCTURE
//  Shared header mem_defs.vh: MT_WORD=2'b00, MT_HALF=2'b01, MT_BYTE=2'b11.
//   Same encoding constants as the load path, so both directions share one definition.
//   Also holds the entry field widths/offsets.
//  Sub-module store_lane_encoder: combinational MemType/addr/data -> {BE, lane data, misaligned}.
//  Top level holds the FIFO storage, pointers, count and the hazard comparators.
// TESTING
//  1 Byte store, addr 0x1003, data 0xAB, MemAck held 1: next cycle MemReq=1, MemAddr=0x400, BE=1000, MemWData=0xABABABAB; popped, QueueEmpty=1 after.
//  2 MemAck=0; 5 back-to-back word stores (DEPTH=4): StallStoreM=1 on the 5th; release ack: entries drain in order, 5th enqueues once count<4.
//  3 Store word 0x2000 queued, unacked; LoadM to 0x2002, same MemorySelect: StallStoreM=1. Same address with MemorySelect=1: no stall.
//  4 Half store at 0x2001 with macro: AdESM=1, count unchanged. Without macro: BE=0011, AdESM=0.
//  5 FlushM=1 with MemWriteM=1: nothing enqueued. Reset while 3 entries pending: QueueEmpty=1, MemReq=0 next cycle.
//  6 Push and pop in the same cycle at count=2: count stays 2; pointer wrap after 4+ cycles keeps FIFO order.

Source files
------------

// File: rtl/store_queue_m_pkg.sv
// Shared memory-access definitions: access-size encodings (same as the load path)
// and queue entry field widths.
package store_queue_m_pkg;

  localparam logic [1:0] MT_WORD = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_BYTE = 2'b11;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  function automatic logic [BE_W-1:0] byte_lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/store_queue_m_if.sv
// Memory-side drain bus of the store queue: the queue (master) presents its head
// entry; data RAM or the device bridge (slave) acknowledges it.
interface store_queue_m_if #(
  parameter int unsigned AW = 32
);
  logic          MemReq;
  logic [AW-3:0] MemAddr;
  logic [31:0]   MemWData;
  logic [3:0]    MemBE;
  logic          MemDevSel;
  logic          MemAck;

  modport master (
    output MemReq, MemAddr, MemWData, MemBE, MemDevSel,
    input  MemAck
  );

  modport slave (
    input  MemReq, MemAddr, MemWData, MemBE, MemDevSel,
    output MemAck
  );
endinterface

// File: rtl/store_queue_m_lane_encoder.sv
// store_lane_encoder: store size/address/data -> byte enables, replicated lane data
// and a misalignment flag (flag only raised when STORE_MISALIGN_TRAP_EN is defined).
module store_lane_encoder
  import store_queue_m_pkg::*;
(
  input  logic [1:0]        mem_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] lane_data,
  output logic              misaligned
);

  logic misaligned_raw;

  // Word/half enables never depend on the ignored low bits, so the
  // force-aligned behaviour falls out when the trap is disabled.
  always_comb begin
    be             = 4'b1111;
    lane_data      = wdata;
    misaligned_raw = 1'b0;
    case (mem_type)
      MT_HALF: begin
        be             = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data      = {2{wdata[15:0]}};
        misaligned_raw = addr_lo[0];
      end
      MT_BYTE: begin
        be             = byte_lane_be(addr_lo);
        lane_data      = {4{wdata[7:0]}};
        misaligned_raw = 1'b0;
      end
      default: begin
        be             = 4'b1111;
        lane_data      = wdata;
        misaligned_raw = (addr_lo != 2'b00);
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned = misaligned_raw;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned_raw;
  assign misaligned        = 1'b0;
`endif

endmodule

// File: rtl/store_queue_m.sv
// Memory-stage store queue: encodes stores, buffers them in a DEPTH-entry FIFO and
// drains them over req/ack. Optional address-error trap via STORE_MISALIGN_TRAP_EN.
module store_queue_m
  import store_queue_m_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic [1:0]        MemTypeM,
  input  logic [AW-1:0]     ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              MemorySelectM,
  input  logic              FlushM,
  input  logic              LoadM,
  output logic              StallStoreM,
  output logic              QueueEmpty,
  output logic              AdESM,
  store_queue_m_if.master   mem
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-3:0]       addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [BE_W-1:0]     be_q   [DEPTH];
  logic                sel_q  [DEPTH];

  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;

  logic [BE_W-1:0]     enc_be;
  logic [DATA_W-1:0]   enc_data;
  logic                misaligned;

  logic                full;
  logic                empty;
  logic                store_live;
  logic                push;
  logic                pop;
  logic                hazard;
  logic [PW-1:0]       offset;

  store_lane_encoder u_enc (
    .mem_type   (MemTypeM),
    .addr_lo    (ALUOutM[1:0]),
    .wdata      (WriteDataM),
    .be         (enc_be),
    .lane_data  (enc_data),
    .misaligned (misaligned)
  );

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign store_live = MemWriteM & ~FlushM;
  assign AdESM      = store_live & misaligned;
  assign push       = store_live & ~full & ~AdESM;
  assign pop        = ~empty & mem.MemAck;

  // An entry is valid when its distance from head is below count; the head is
  // still compared in the cycle it is acked.
  always_comb begin
    hazard = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - head;
      if (({1'b0, offset} < count) &&
          (addr_q[i] == ALUOutM[AW-1:2]) &&
          (sel_q[i] == MemorySelectM))
        hazard = 1'b1;
    end
  end

  assign StallStoreM = (store_live & full & ~AdESM) | (LoadM & hazard);
  assign QueueEmpty  = empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
        sel_q[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= ALUOutM[AW-1:2];
        data_q[tail] <= enc_data;
        be_q[tail]   <= enc_be;
        sel_q[tail]  <= MemorySelectM;
        tail         <= tail + PW'(1);
      end
      if (pop)
        head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign mem.MemReq    = ~empty;
  assign mem.MemAddr   = addr_q[head];
  assign mem.MemWData  = data_q[head];
  assign mem.MemBE     = be_q[head];
  assign mem.MemDevSel = sel_q[head];

endmodule

// File: tb/tb_store_queue_m.sv
// Scoreboard bench for store_queue_m: a reference queue model checks handshake,
// stall, empty and head fields every cycle on the falling edge.
module tb_store_queue_m;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [1:0]  MemTypeM = 2'b00;
  logic [31:0] ALUOutM = '0;
  logic [31:0] WriteDataM = '0;
  logic        MemorySelectM = 1'b0;
  logic        FlushM = 1'b0;
  logic        LoadM = 1'b0;
  logic        StallStoreM;
  logic        QueueEmpty;
  logic        AdESM;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        sel;
  } ent_t;

  ent_t sb[$];

  store_queue_m_if #(.AW(32)) mem_bus ();

  store_queue_m #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWriteM     (MemWriteM),
    .MemTypeM      (MemTypeM),
    .ALUOutM       (ALUOutM),
    .WriteDataM    (WriteDataM),
    .MemorySelectM (MemorySelectM),
    .FlushM        (FlushM),
    .LoadM         (LoadM),
    .StallStoreM   (StallStoreM),
    .QueueEmpty    (QueueEmpty),
    .AdESM         (AdESM),
    .mem           (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_enc(input logic [1:0] t, input logic [1:0] a, input logic [31:0] d,
                                    output logic [3:0] be, output logic [31:0] dat, output logic mis);
    case (t)
      2'b01: begin
        dat = {d[15:0], d[15:0]};
        be  = a[1] ? 4'hC : 4'h3;
        mis = a[0];
      end
      2'b11: begin
        dat = {d[7:0], d[7:0], d[7:0], d[7:0]};
        case (a)
          2'd0: be = 4'h1;
          2'd1: be = 4'h2;
          2'd2: be = 4'h4;
          default: be = 4'h8;
        endcase
        mis = 1'b0;
      end
      default: begin
        dat = d;
        be  = 4'hF;
        mis = (a != 2'd0);
      end
    endcase
  endfunction

  // Reference model: sampled on the falling edge, applied as of the next rising edge.
  always @(negedge clk) begin
    logic [3:0]  e_be;
    logic [31:0] e_dat;
    logic        mis, e_ades, e_full, e_haz, e_stall, e_req, wr;
    ent_t        e;
    model_enc(MemTypeM, ALUOutM[1:0], WriteDataM, e_be, e_dat, mis);
    wr = MemWriteM && !FlushM;
`ifdef STORE_MISALIGN_TRAP_EN
    e_ades = wr && mis;
`else
    e_ades = 1'b0;
`endif
    e_req  = (sb.size() != 0);
    e_full = (sb.size() == DEPTH);
    e_haz  = 1'b0;
    foreach (sb[k])
      if (sb[k].addr == ALUOutM[31:2] && sb[k].sel == MemorySelectM) e_haz = 1'b1;
    e_stall = (wr && e_full && !e_ades) || (LoadM && e_haz);
    check_eq("mem_req", mem_bus.MemReq, e_req);
    check_eq("queue_empty", QueueEmpty, !e_req);
    check_eq("ades", AdESM, e_ades);
    check_eq("stall", StallStoreM, e_stall);
    if (e_req)
      check_eq("head", {mem_bus.MemAddr, mem_bus.MemWData, mem_bus.MemBE, mem_bus.MemDevSel},
               {sb[0].addr, sb[0].data, sb[0].be, sb[0].sel});
    if (reset) begin
      sb.delete();
    end else begin
      if (e_req && mem_bus.MemAck) void'(sb.pop_front());
      if (wr && !e_full && !e_ades) begin
        e.addr = ALUOutM[31:2];
        e.data = e_dat;
        e.be   = e_be;
        e.sel  = MemorySelectM;
        sb.push_back(e);
      end
    end
  end

  task automatic do_store(input logic [1:0] t, input logic [31:0] addr, input logic [31:0] data,
                          input logic sel);
    logic st;
    st = 1'b1;
    MemWriteM = 1'b1;
    MemTypeM = t;
    ALUOutM = addr;
    WriteDataM = data;
    MemorySelectM = sel;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      st = StallStoreM;
      @(posedge clk);
      #1;
      if (!st) break;
    end
    check_eq("store_accept", st, 1'b0);
    MemWriteM = 1'b0;
  endtask

  task automatic wait_empty();
    mem_bus.MemAck = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (QueueEmpty) break;
    end
    check_eq("drain_empty", QueueEmpty, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic st;
    mem_bus.MemAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_fields", {mem_bus.MemReq, mem_bus.MemAddr, mem_bus.MemWData, mem_bus.MemBE,
                            mem_bus.MemDevSel, QueueEmpty, StallStoreM, AdESM},
             {1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;

    // 1: byte store, ack held high
    mem_bus.MemAck = 1'b1;
    do_store(2'b11, 32'h1003, 32'hAB, 1'b0);
    @(negedge clk);
    check_eq("t1_addr", mem_bus.MemAddr, 30'h400);
    check_eq("t1_be", mem_bus.MemBE, 4'b1000);
    check_eq("t1_data", mem_bus.MemWData, 32'hABABABAB);
    @(negedge clk);
    check_eq("t1_empty", QueueEmpty, 1'b1);
    @(posedge clk);
    #1;

    // 2: fill to full, fifth store stalls until ack resumes
    mem_bus.MemAck = 1'b0;
    for (int i = 0; i < 4; i++) do_store(2'b00, 32'h100 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 1'b0);
    MemWriteM = 1'b1;
    MemTypeM = 2'b00;
    ALUOutM = 32'h200;
    WriteDataM = 32'h55555555;
    @(negedge clk);
    check_eq("t2_stall5", StallStoreM, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    mem_bus.MemAck = 1'b1;
    st = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      st = StallStoreM;
      @(posedge clk);
      #1;
      if (!st) break;
    end
    check_eq("t2_fifth_taken", st, 1'b0);
    MemWriteM = 1'b0;
    wait_empty();

    // 3: load hazard against a queued word
    mem_bus.MemAck = 1'b0;
    do_store(2'b00, 32'h2000, 32'h11223344, 1'b0);
    LoadM = 1'b1;
    ALUOutM = 32'h2002;
    MemorySelectM = 1'b0;
    @(negedge clk);
    check_eq("t3_haz", StallStoreM, 1'b1);
    @(posedge clk);
    #1;
    MemorySelectM = 1'b1;
    @(negedge clk);
    check_eq("t3_nohaz_sel", StallStoreM, 1'b0);
    @(posedge clk);
    #1;
    LoadM = 1'b0;
    MemorySelectM = 1'b0;
    wait_empty();

    // 4: misaligned half store
    mem_bus.MemAck = 1'b0;
    MemWriteM = 1'b1;
    MemTypeM = 2'b01;
    ALUOutM = 32'h2001;
    WriteDataM = 32'h0000BEEF;
    @(negedge clk);
`ifdef STORE_MISALIGN_TRAP_EN
    check_eq("t4_ades", AdESM, 1'b1);
`else
    check_eq("t4_ades", AdESM, 1'b0);
`endif
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
    @(negedge clk);
`ifdef STORE_MISALIGN_TRAP_EN
    check_eq("t4_not_queued", QueueEmpty, 1'b1);
`else
    check_eq("t4_be", mem_bus.MemBE, 4'b0011);
    check_eq("t4_data", mem_bus.MemWData, 32'hBEEFBEEF);
`endif
    wait_empty();

    // 5: flushed store is dropped; reset discards pending entries
    mem_bus.MemAck = 1'b0;
    MemWriteM = 1'b1;
    FlushM = 1'b1;
    MemTypeM = 2'b00;
    ALUOutM = 32'h3000;
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
    FlushM = 1'b0;
    @(negedge clk);
    check_eq("t5_flush", QueueEmpty, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) do_store(2'b11, 32'h3000 + 32'(i), 32'h10 + 32'(i), 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_req", mem_bus.MemReq, 1'b0);
    check_eq("t5_rst_empty", QueueEmpty, 1'b1);
    @(posedge clk);
    #1;

    // 6: steady push+pop at count=2 across pointer wrap
    mem_bus.MemAck = 1'b0;
    do_store(2'b00, 32'h4000, 32'hA0000000, 1'b0);
    do_store(2'b00, 32'h4004, 32'hA0000001, 1'b1);
    mem_bus.MemAck = 1'b1;
    for (int i = 0; i < 6; i++)
      do_store(2'(i % 2 ? 2'b01 : 2'b11), 32'h5000 + 32'(i * 2), 32'h1234 + 32'(i * 7), 1'(i % 2));
    mem_bus.MemAck = 1'b0;
    @(negedge clk);
    check_eq("t6_not_empty", QueueEmpty, 1'b0);
    @(posedge clk);
    #1;
    wait_empty();

    // random mix to exercise wrap, hazards and ack gaps
    for (int n = 0; n < 120; n++) begin
      MemWriteM = 1'($urandom_range(0, 1));
      MemTypeM = 2'($urandom_range(0, 3));
      ALUOutM = 32'h6000 + 32'($urandom_range(0, 15));
      WriteDataM = $urandom;
      MemorySelectM = 1'($urandom_range(0, 1));
      FlushM = ($urandom_range(0, 7) == 0);
      LoadM = 1'($urandom_range(0, 1));
      mem_bus.MemAck = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    MemWriteM = 1'b0;
    FlushM = 1'b0;
    LoadM = 1'b0;
    wait_empty();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
